avalon_mm_csr_bank: RTL

//  Parametrised Avalon-MM slave CSR bank: NUM_REGS read/write control registers plus NUM_REGS

---
 rtl/avalon_mm_csr_bank.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/avalon_mm_csr_bank.sv
// Avalon-MM slave CSR bank: NUM_REGS read/write control registers and NUM_REGS read-only
// status words, with programmable wait states and a fixed-latency pipelined read path.
module avalon_mm_csr_bank #(
    parameter int unsigned       DWIDTH       = 32,
    parameter int unsigned       NUM_REGS     = 4,
    parameter int unsigned       AWIDTH       = $clog2(NUM_REGS) + 1,
    parameter int unsigned       WAIT_STATES  = 0,
    parameter int unsigned       READ_LATENCY = 1,
    parameter logic [DWIDTH-1:0] CTRL_RST_VAL = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [AWIDTH-1:0]            address_i,
    input  logic                         write_i,
    input  logic [DWIDTH-1:0]            writedata_i,
    input  logic [DWIDTH/8-1:0]          byteenable_i,
    input  logic                         read_i,
    output logic                         waitrequest_o,
    output logic [DWIDTH-1:0]            readdata_o,
    output logic                         readdatavalid_o,
    output logic [NUM_REGS*DWIDTH-1:0]   ctrl_o,
    output logic [NUM_REGS-1:0]          ctrl_wr_stb_o,
    input  logic [NUM_REGS*DWIDTH-1:0]   status_i
);

    localparam int unsigned BYTES   = DWIDTH / 8;
    localparam int unsigned AW1     = AWIDTH + 1;
    localparam logic [3:0]  WS_LAST = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCEPT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 req;
    logic                 accept;
    logic                 stall;
    logic                 do_wr;
    logic                 do_rd;
    logic [AW1-1:0]       addr_ext;
    logic [NUM_REGS-1:0]  wr_sel;
    logic [NUM_REGS-1:0]  stb_q;
    logic [DWIDTH-1:0]    rd_word;
    logic [DWIDTH-1:0]    ctrl_q [NUM_REGS];
    logic [READ_LATENCY-1:0] vld_q;
    logic [DWIDTH-1:0]    dat_q [READ_LATENCY];

    assign req      = read_i | write_i;
    assign addr_ext = {1'b0, address_i};

    // cnt counts stall cycles already spent; the IDLE cycle that sees the request is the first.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        stall   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        accept = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        cnt_d   = 4'd1;
                        state_d = (WAIT_STATES == 1) ? S_ACCEPT : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (!req) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == WS_LAST) state_d = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                accept  = req;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign waitrequest_o = rst_i | stall;

    // A simultaneous read and write performs only the write.
    assign do_wr = accept & write_i;
    assign do_rd = accept & read_i & ~write_i;

    always_comb begin
        wr_sel  = '0;
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_sel[i] = do_wr && (addr_ext == AW1'(i));
            if (addr_ext == AW1'(i))            rd_word = ctrl_q[i];
            if (addr_ext == AW1'(NUM_REGS + i)) rd_word = status_i[i*DWIDTH +: DWIDTH];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stb_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) ctrl_q[i] <= CTRL_RST_VAL;
        end else begin
            stb_q <= wr_sel;
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (wr_sel[i] && byteenable_i[b]) ctrl_q[i][b*8 +: 8] <= writedata_i[b*8 +: 8];
                end
            end
        end
    end

    // Each stage's data only moves with its valid bit, so the last stage holds the last response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            for (int k = 0; k < READ_LATENCY; k++) dat_q[k] <= '0;
        end else begin
            vld_q[0] <= do_rd;
            if (do_rd) dat_q[0] <= rd_word;
            for (int k = 1; k < READ_LATENCY; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) dat_q[k] <= dat_q[k-1];
            end
        end
    end

    assign readdatavalid_o = vld_q[READ_LATENCY-1];
    assign readdata_o      = dat_q[READ_LATENCY-1];
    assign ctrl_wr_stb_o   = stb_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_ctrl
        assign ctrl_o[g*DWIDTH +: DWIDTH] = ctrl_q[g];
    end

endmodule
